// File: rtl/vec_mem_unit.sv
// vec_mem_unit: VLD/VST memory-side executor. It moves one LANES x DW vector between the
// vector datapath and a word-addressed data memory, one lane per handshake. Optional feature macro: VMEM_TIMEOUT_EN.
module vec_mem_unit #(
    parameter int LANES   = 16,
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                op,
    input  logic [AW-1:0]       base_addr,
    input  logic [LANES*DW-1:0] st_data,
    output logic [LANES*DW-1:0] ld_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                mem_re,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    input  logic                mem_ack
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("vec_mem_unit: TIMEOUT must be at least 1");
    end

    state_t              state_q, state_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic                op_q, op_d;
    logic                re_q, re_d;
    logic                we_q, we_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic                done_q, done_d;
    logic [LANES*DW-1:0] ld_q, ld_d;

    logic [AW-1:0]       base_q;
    logic [LANES*DW-1:0] st_q;
    logic [LANES*DW-1:0] shadow_q, shadow_d;

    logic capture;
    logic req;
    logic req_ack;

`ifdef VMEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic          timeout;

    assign timeout = req && !mem_ack && (wait_q == TW'(TIMEOUT - 1));
`endif

    assign capture = (state_q == IDLE) && start;
    assign req     = re_q || we_q;
    assign req_ack = req && mem_ack;

    // The last lane is merged in so ld_data is complete in the same cycle as done.
    always_comb begin
        shadow_d = shadow_q;
        if (req_ack && !op_q) begin
            shadow_d[int'(lane_q)*DW +: DW] = mem_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        op_d    = op_q;
        re_d    = re_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        ld_d    = ld_q;
`ifdef VMEM_TIMEOUT_EN
        wait_d  = wait_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCESS;
                    lane_d  = '0;
                    op_d    = op;
                end
            end
            ACCESS: begin
                if (req_ack) begin
                    // Request drops for one cycle so every lane gets a fresh handshake.
                    re_d   = 1'b0;
                    we_d   = 1'b0;
                    lane_d = lane_q + 1'b1;
                    if (lane_q == LAST_LANE) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        if (!op_q) begin
                            ld_d = shadow_d;
                        end
                    end
                end else if (!req) begin
                    re_d    = !op_q;
                    we_d    = op_q;
                    addr_d  = base_q + AW'(lane_q);
                    wdata_d = st_q[int'(lane_q)*DW +: DW];
`ifdef VMEM_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
`ifdef VMEM_TIMEOUT_EN
                else if (timeout) begin
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = FINISH;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            op_q    <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            op_q    <= op_d;
            re_q    <= re_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ld_q    <= ld_d;
        end
    end

    // Operand captures and the load shadow need no reset; they are always rewritten before use.
    always_ff @(posedge clk) begin
        if (capture) begin
            base_q <= base_addr;
            st_q   <= st_data;
        end
        shadow_q <= shadow_d;
    end

`ifdef VMEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ld_data   = ld_q;
    assign busy      = (state_q == ACCESS);
    assign done      = done_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_vec_mem_unit.sv
// Self-checking bench for vec_mem_unit: a behavioural memory with random wait states and stray acks,
// plus a whole-vector reference model of loads, stores and address wrap.
`timescale 1ns/1ps
module tb_vec_mem_unit;
    localparam int LANES = 16;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int VW    = LANES * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [VW-1:0] st_data = '0;
    logic [VW-1:0] ld_data;
    logic          busy, done, err;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    vec_mem_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .base_addr(base_addr),
        .st_data(st_data), .ld_data(ld_data), .busy(busy), .done(done), .err(err),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:65535];
    logic [AW-1:0] log_addr[$];
    logic          log_we[$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            wait_cfg = 0;
    bit            rand_wait = 0;
    bit            spurious = 0;
    int            hang_lane = -1;
    int            ack_cnt = 0;
    int            req_age = 0;
    logic          cur_op = 1'b0;
    logic [VW-1:0] model_ld = '0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Memory responder: acks after a configurable number of request cycles, checks request discipline.
    initial begin : responder
        int            cur_wait;
        logic          s_re, s_we;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        cur_wait  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = DW'($urandom);
            if (rst_n && (mem_re || mem_we)) begin
                if (req_age == 0) begin
                    s_re = mem_re; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
                    cur_wait = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
                    chk("req_onehot", mem_re && mem_we, 1'b0);
                    chk("req_kind", mem_we, cur_op);
                end else begin
                    chk("req_stable", {mem_re, mem_we, mem_addr, mem_wdata}, {s_re, s_we, s_addr, s_wdata});
                end
                if (req_age >= cur_wait && ack_cnt != hang_lane) begin
                    mem_ack = 1'b1;
                    if (mem_re) mem_rdata = mem[mem_addr];
                    else mem[mem_addr] = mem_wdata;
                    log_addr.push_back(mem_addr);
                    log_we.push_back(mem_we);
                    ack_cnt++;
                    req_age = 0;
                end else begin
                    req_age++;
                end
            end else begin
                req_age = 0;
                if (spurious && $urandom_range(0, 1) == 1) mem_ack = 1'b1;
            end
        end
    end

    task automatic begin_op(input logic o, input logic [AW-1:0] base, input logic [VW-1:0] sd);
        ack_cnt = 0;
        log_addr.delete();
        log_we.delete();
        cur_op    = o;
        op        = o;
        base_addr = base;
        st_data   = sd;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        op        = ~o;
        base_addr = AW'($urandom);
        st_data   = {8{32'($urandom)}};
        chk("busy_after_start", busy, 1'b1);
    endtask

    // Runs one transfer and checks it against the whole-vector model; exp_lat = 0 skips the latency check.
    task automatic run_op(input logic o, input logic [AW-1:0] base, input logic [VW-1:0] sd,
                          input int exp_lat, input bit disturb);
        logic [VW-1:0] exp_ld;
        int            cyc;
        exp_ld = model_ld;
        if (!o) for (int i = 0; i < LANES; i++) exp_ld[i*DW +: DW] = mem[AW'(base + i)];
        begin_op(o, base, sd);
        cyc = 1;
        while (!done && cyc < 3000) begin
            if (disturb) start = (cyc == 9);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", done, 1'b1);
        if (exp_lat > 0) chk("latency", cyc, exp_lat);
        chk("busy_low_at_done", busy, 1'b0);
        chk("err_low_at_done", err, 1'b0);
        chk("ld_data", ld_data, exp_ld);
        chk("access_count", log_addr.size(), LANES);
        for (int i = 0; i < LANES && i < log_addr.size(); i++) begin
            chk("access_addr", log_addr[i], AW'(base + i));
            chk("access_we", log_we[i], o);
        end
        if (o) for (int i = 0; i < LANES; i++) chk("stored_word", mem[AW'(base + i)], sd[i*DW +: DW]);
        @(negedge clk);
        chk("done_single", done, 1'b0);
        chk("ld_hold", ld_data, exp_ld);
        model_ld = exp_ld;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [VW-1:0] sd;
        int            cyc;
        bit            seen;
        for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < LANES; i++) mem[16'h0100 + i] = 16'h1000 + DW'(i);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_re_we", {mem_re, mem_we}, 2'b00);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_wdata", mem_wdata, 16'h0);
        chk("rst_ld", ld_data, 256'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait load, then address wrap
        run_op(1'b0, 16'h0100, '0, 2 * LANES + 1, 1'b0);
        run_op(1'b0, 16'hFFF8, '0, 2 * LANES + 1, 1'b0);

        // Store with 3 wait cycles per lane
        wait_cfg = 3;
        for (int i = 0; i < LANES; i++) sd[i*DW +: DW] = 16'hA0A0 ^ DW'(i);
        run_op(1'b1, 16'h0400, sd, 0, 1'b0);

        // Ignored mid-operation start, then back-to-back start in the cycle after done
        wait_cfg = 0;
        run_op(1'b0, 16'h0400, '0, 2 * LANES + 1, 1'b1);
        run_op(1'b1, 16'h7FF0, {8{32'hDEADBEEF}}, 2 * LANES + 1, 1'b1);

        // Random transfers with random wait states and stray acks between requests
        rand_wait = 1;
        spurious  = 1;
        for (int n = 0; n < 10; n++) begin
            sd = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
                  32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            run_op(1'($urandom), (n % 3 == 0) ? AW'($urandom_range(16'hFFF0, 16'hFFFF)) : AW'($urandom),
                   sd, 0, 1'b0);
        end
        rand_wait = 0;
        spurious  = 0;
        if (model_ld == '0) run_op(1'b0, 16'h0100, '0, 2 * LANES + 1, 1'b0);

        // Asynchronous reset during lane 7 of a load
        wait_cfg = 2;
        begin_op(1'b0, 16'h0200, '0);
        cyc = 0;
        while (!(ack_cnt == 7 && mem_re) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_lane7", (ack_cnt == 7) && mem_re, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_re", mem_re, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ld", ld_data, 256'h0);
        chk("mid_rst_addr", mem_addr, 16'h0);
        @(negedge clk);
        chk("mid_rst_done", done, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", done, 1'b0);
        model_ld = '0;
        wait_cfg = 0;
        run_op(1'b0, 16'h0100, '0, 2 * LANES + 1, 1'b0);

        // Memory never acks lane 4
        hang_lane = 4;
        begin_op(1'b0, 16'h0300, '0);
        cyc  = 1;
        seen = 0;
`ifdef VMEM_TIMEOUT_EN
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_done", done, 1'b1);
        chk("to_err", err, 1'b1);
        chk("to_latency", cyc, 2 * 4 + 2 + 255);
        chk("to_re_low", mem_re, 1'b0);
        chk("to_ld_kept", ld_data, model_ld);
        @(negedge clk);
        chk("to_err_pulse", {done, err}, 2'b00);
        chk("to_ld_hold", ld_data, model_ld);
        hang_lane = -1;
`else
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1;
        end
        chk("hang_no_done", seen, 1'b0);
        chk("hang_busy", busy, 1'b1);
        chk("hang_re_held", mem_re, 1'b1);
        chk("hang_err", err, 1'b0);
        chk("hang_ld_kept", ld_data, model_ld);
        hang_lane = -1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_ld = '0;
`endif
        run_op(1'b0, 16'hFFF8, '0, 2 * LANES + 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vec_mem_unit.md
Name: vec_mem_unit

Overview:
- Memory-side executor for VLD/VST. Takes the 16-bit effective address computed for VLD/VST and moves one 256-bit vector (16 lanes x 16 bits) between the vector datapath and a 16-bit word-addressed data memory.
- Transfers one lane per memory handshake and sequences all 16 lanes.
- Sits between the execute stage and data memory. The pipeline stalls on busy.

Parameters:
- LANES, 16, number of 16-bit lanes per vector.
- DW, 16, lane and memory data width in bits.
- AW, 16, memory address width in bits.
- TIMEOUT, 255, cycles to wait for mem_ack before abort (used only with VMEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- op  in  1  0 = vector load (VLD), 1 = vector store (VST).
- base_addr  in  AW  address of lane 0.
- st_data  in  LANES*DW  vector to store; lane i = bits [16i+15:16i].
- ld_data  out  LANES*DW  loaded vector.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done on an aborted operation.
- mem_re  out  1  memory read request.
- mem_we  out  1  memory write request.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data; valid when mem_ack = 1.
- mem_ack  in  1  memory completes the current request this cycle.

Behaviour:
- Reset values: ld_data = 0, busy = 0, done = 0, err = 0, mem_re = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. State = IDLE, lane counter = 0.
- States: IDLE, ACCESS, FINISH.
- IDLE -> ACCESS when start = 1:
  - Register op, base_addr and st_data; clear the lane counter.
  - busy = 1 from the next cycle onward.
- ACCESS:
  - mem_addr = base_addr + lane, truncated to AW bits (wraps 0xFFFF -> 0x0000).
  - Exactly one of mem_re / mem_we is high, chosen by op.
  - mem_wdata = captured st_data lane.
  - Request signals stay stable until mem_ack.
- On mem_ack in ACCESS:
  - Load: write mem_rdata into an internal shadow lane.
  - Lane counter increments.
  - mem_re / mem_we drop for one cycle between lanes: one request per lane, no back-to-back reuse of a held request.
  - After lane LANES-1 acks, go to FINISH.
- mem_ack while no request is high is ignored.
- FINISH:
  - done = 1 for one cycle, busy = 0 in the same cycle; return to IDLE.
  - Load only: ld_data updates atomically from the shadow buffer on the FINISH edge. ld_data never shows a partially loaded vector and holds its value otherwise.
- Latency with zero-wait memory (mem_ack in the first request cycle): start -> done = 2 x LANES + 1 cycles (33).
- start while busy is ignored. A new start is accepted in IDLE in the cycle after done.
- Stability: st_data and base_addr changes after capture have no effect.
- Reset mid-operation: all outputs return to reset values immediately (async). The transfer is abandoned and ld_data is cleared; no done is issued.

Optional Feature:
- Macro: VMEM_TIMEOUT_EN.
- With the macro:
  - A per-lane wait counter clears on every new request.
  - If mem_ack is absent for TIMEOUT consecutive request cycles: drop the request, go to FINISH, pulse done and err together.
  - ld_data is left unchanged on abort.
- Without the macro:
  - No counter; the unit waits indefinitely for mem_ack.
  - err is tied 0.

Test Plan:
- Load, zero-wait: memory[0x0100+i] = 0x1000+i; start op=0 base=0x0100 -> 16 reads at 0x0100..0x010F, done at cycle 33, ld_data lane i = 0x1000+i, busy low with done.
- Store with wait states: st_data lane i = 0xA0A0^i, mem_ack after 3 cycles per lane -> writes to base..base+15 with matching data, request stable until ack, done once, ld_data unchanged.
- Address wrap: load base=0xFFF8 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007, in order.
- start pulsed mid-operation with a different base and op -> ignored; the original transfer completes unchanged; start in the cycle after done is accepted.
- rst_n low during lane 7 of a load -> mem_re drops immediately, ld_data = 0, no done; a following load completes normally.
- VMEM_TIMEOUT_EN with mem_ack held low on lane 4 -> after 255 cycles done and err pulse together, mem_re low, ld_data keeps its previous value; without the macro, busy stays high.
